// File: rtl/lighthouse_emitter.sv
// lighthouse_emitter
//   Synthetic lighthouse base-station pair for loopback/self-test of the
//   sweep-capture path. Each frame carries two sync pulses (station A at t=0,
//   station B at t=SYNC_GAP) whose lengths encode {skip, data, axis}, followed
//   by one sweep pulse at the programmed time. Output idles high and pulses
//   low, matching the optical sensor polarity.
//
// Ports
//   clk_48        in   system clock
//   reset         in   synchronous, active-high
//   en            in   run enable; low aborts the frame and holds idle
//   sweep_time    in   clocks from frame start to the sweep falling edge
//   data0, data1  in   OOTX data bits for station A / station B sync
//   out           out  emitted waveform, idle high, pulses low
//   frame_strobe  out  1-cycle pulse at frame start (t=0)
//   frame_idx     out  [0]=axis, [1]=sweeping station (0=A, 1=B)
//   sweep_err     out  1-cycle pulse at t=0 when the latched sweep_time is invalid
//
// All outputs are registered, so they describe the frame time t processed in
// the previous clock cycle.
module lighthouse_emitter #(
    parameter int FRAME     = 400000,
    parameter int SYNC_BASE = 3000,
    parameter int SYNC_STEP = 500,
    parameter int SYNC_GAP  = 19200,
    parameter int SWEEP_LEN = 480,
    parameter int WIDTH     = 24
) (
    input  logic             clk_48,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] sweep_time,
    input  logic             data0,
    input  logic             data1,
    output logic             out,
    output logic             frame_strobe,
    output logic [1:0]       frame_idx,
    output logic             sweep_err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Range arithmetic is done one bit wider so S+SWEEP_LEN and
    // SYNC_GAP+L1 cannot wrap.
    localparam logic [WIDTH:0]   FRAME_X   = (WIDTH+1)'(FRAME);
    localparam logic [WIDTH:0]   GAP_X     = (WIDTH+1)'(SYNC_GAP);
    localparam logic [WIDTH:0]   SWEEP_X   = (WIDTH+1)'(SWEEP_LEN);
    // Earliest sweep start: clears the longest possible sync1 (code 7).
    localparam logic [WIDTH:0]   S_MIN_X   = (WIDTH+1)'(SYNC_GAP + SYNC_BASE + 8 * SYNC_STEP);
    localparam logic [WIDTH-1:0] LAST_T    = WIDTH'(FRAME - 1);
    localparam logic [WIDTH-1:0] BASE_W    = WIDTH'(SYNC_BASE);
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(SYNC_STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [1:0]       frame_idx_q, frame_idx_d;
    logic [WIDTH-1:0] l0_q, l0_d, l1_q, l1_d, s_q, s_d;
    logic             valid_q, valid_d;
    logic             out_q, out_d;
    logic             strobe_q, strobe_d;
    logic             err_q, err_d;

    // Frame time handled this cycle; an idle block always starts at t=0.
    logic [WIDTH-1:0] cur_t;
    logic             frame_start;
    logic [1:0]       idx_now;
    logic [2:0]       code0, code1;
    logic [WIDTH-1:0] len0_new, len1_new;
    logic             valid_new;
    // Per-frame parameters in effect this cycle: freshly computed at t=0,
    // shadow registers for the rest of the frame.
    logic [WIDTH-1:0] f_l0, f_l1, f_s;
    logic             f_valid;
    logic [WIDTH:0]   t_x;
    logic             in_sync0, in_sync1, in_sweep;

    assign cur_t       = (state_q == RUN) ? t_q : '0;
    assign frame_start = (cur_t == '0);
    // t_q can only be 0 while running after a wrap, so that is the one place
    // the index advances; a fresh start from idle reuses the current index.
    assign idx_now     = (state_q == RUN && t_q == '0) ? frame_idx_q + 2'd1 : frame_idx_q;

    assign code0    = {idx_now[1], data0, idx_now[0]};
    assign code1    = {~idx_now[1], data1, idx_now[0]};
    assign len0_new = BASE_W + STEP_W * WIDTH'(code0);
    assign len1_new = BASE_W + STEP_W * WIDTH'(code1);
    assign valid_new = ({1'b0, sweep_time} >= S_MIN_X) &&
                       ({1'b0, sweep_time} + SWEEP_X <= FRAME_X);

    assign f_l0    = frame_start ? len0_new   : l0_q;
    assign f_l1    = frame_start ? len1_new   : l1_q;
    assign f_s     = frame_start ? sweep_time : s_q;
    assign f_valid = frame_start ? valid_new  : valid_q;

    assign t_x      = {1'b0, cur_t};
    assign in_sync0 = t_x < {1'b0, f_l0};
    assign in_sync1 = (t_x >= GAP_X) && (t_x < GAP_X + {1'b0, f_l1});
    assign in_sweep = f_valid && (t_x >= {1'b0, f_s}) && (t_x < {1'b0, f_s} + SWEEP_X);

    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        frame_idx_d = frame_idx_q;
        l0_d        = l0_q;
        l1_d        = l1_q;
        s_d         = s_q;
        valid_d     = valid_q;
        out_d       = 1'b1;
        strobe_d    = 1'b0;
        err_d       = 1'b0;

        if (!en) begin
            state_d = IDLE;
            t_d     = '0;
        end else begin
            state_d  = RUN;
            t_d      = (cur_t == LAST_T) ? '0 : cur_t + WIDTH'(1);
            out_d    = !(in_sync0 || in_sync1 || in_sweep);
            strobe_d = frame_start;
            if (frame_start) begin
                frame_idx_d = idx_now;
                l0_d        = len0_new;
                l1_d        = len1_new;
                s_d         = sweep_time;
                valid_d     = valid_new;
                err_d       = !valid_new;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_48) begin
        if (reset) begin
            state_q     <= IDLE;
            t_q         <= '0;
            frame_idx_q <= 2'd0;
            l0_q        <= '0;
            l1_q        <= '0;
            s_q         <= '0;
            valid_q     <= 1'b0;
            out_q       <= 1'b1;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            frame_idx_q <= frame_idx_d;
            l0_q        <= l0_d;
            l1_q        <= l1_d;
            s_q         <= s_d;
            valid_q     <= valid_d;
            out_q       <= out_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
        end
    end

    assign out          = out_q;
    assign frame_strobe = strobe_q;
    assign frame_idx    = frame_idx_q;
    assign sweep_err    = err_q;

endmodule

// File: tb/tb_lighthouse_emitter.sv
// Testbench for lighthouse_emitter with reduced frame parameters.
// A behavioural reference predicts the registered outputs for every cycle;
// predictions go into a scoreboard queue when inputs are driven and are
// compared after the clock edge. Directed checks pin waveform edges to the
// constants worked out by hand for each scenario.
module tb_lighthouse_emitter;

    localparam int FRAME     = 2000;
    localparam int SYNC_BASE = 60;
    localparam int SYNC_STEP = 10;
    localparam int SYNC_GAP  = 200;
    localparam int SWEEP_LEN = 10;
    localparam int WIDTH     = 24;

    logic             clk_48 = 1'b0;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] sweep_time;
    logic             data0, data1;
    logic             out, frame_strobe, sweep_err;
    logic [1:0]       frame_idx;

    lighthouse_emitter #(
        .FRAME(FRAME), .SYNC_BASE(SYNC_BASE), .SYNC_STEP(SYNC_STEP),
        .SYNC_GAP(SYNC_GAP), .SWEEP_LEN(SWEEP_LEN), .WIDTH(WIDTH)
    ) dut (
        .clk_48      (clk_48),
        .reset       (reset),
        .en          (en),
        .sweep_time  (sweep_time),
        .data0       (data0),
        .data1       (data1),
        .out         (out),
        .frame_strobe(frame_strobe),
        .frame_idx   (frame_idx),
        .sweep_err   (sweep_err)
    );

    always #5 clk_48 = ~clk_48;

    typedef struct packed {
        logic       out;
        logic       strobe;
        logic [1:0] idx;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference state: running flag, next frame time, frame index and the
    // per-frame values captured at t=0.
    bit m_run = 0;
    int m_t   = 0;
    int m_idx = 0;
    int m_l0, m_l1, m_s;
    bit m_valid;
    int m_last_t = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Predict the outputs produced by the inputs currently driven.
    function automatic exp_t predict();
        exp_t e;
        int   t;
        e = '{out: 1'b1, strobe: 1'b0, idx: 2'(m_idx), err: 1'b0};
        if (reset) begin
            m_run = 0; m_t = 0; m_idx = 0; m_last_t = -1;
            e.idx = 2'd0;
        end else if (!en) begin
            m_run = 0; m_t = 0; m_last_t = -1;
        end else begin
            t = m_run ? m_t : 0;
            if (t == 0) begin
                if (m_run) m_idx = (m_idx + 1) % 4;
                m_l0 = SYNC_BASE + SYNC_STEP * ((m_idx / 2) * 4 + int'(data0) * 2 + (m_idx % 2));
                m_l1 = SYNC_BASE + SYNC_STEP * ((1 - m_idx / 2) * 4 + int'(data1) * 2 + (m_idx % 2));
                m_s  = int'(sweep_time);
                m_valid = (m_s >= SYNC_GAP + SYNC_BASE + 8 * SYNC_STEP) && (m_s + SWEEP_LEN <= FRAME);
                e.strobe = 1'b1;
                e.err    = !m_valid;
            end
            e.idx = 2'(m_idx);
            if (t < m_l0 || (t >= SYNC_GAP && t < SYNC_GAP + m_l1) ||
                (m_valid && t >= m_s && t < m_s + SWEEP_LEN))
                e.out = 1'b0;
            m_last_t = t;
            m_t   = (t + 1) % FRAME;
            m_run = 1;
        end
        return e;
    endfunction

    // One clock: push prediction, clock, pop and compare just after the edge.
    task automatic cycle();
        exp_t e;
        sb_q.push_back(predict());
        @(posedge clk_48);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check($sformatf("sb t=%0d", m_last_t), {27'd0, out, frame_strobe, frame_idx, sweep_err}, {27'd0, e});
    endtask

    // Advance until the visible outputs belong to frame time target.
    task automatic run_to(input int target);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (m_last_t != target && n < 3 * FRAME);
        if (m_last_t != target) begin
            checks++;
            failures++;
            $display("FAIL run_to observed_t=%0d expected_t=%0d", m_last_t, target);
        end
    endtask

    int prev_cyc;
    int saved_idx;

    initial begin
        reset = 1'b1; en = 1'b1; data0 = 1'b1; data1 = 1'b0; sweep_time = WIDTH'(1000);
        repeat (3) cycle();
        check("rst_out",    32'(out),          32'd1);
        check("rst_strobe", 32'(frame_strobe), 32'd0);
        check("rst_idx",    32'(frame_idx),    32'd0);
        check("rst_err",    32'(sweep_err),    32'd0);

        // Frame 0: L0=80, L1=100, sweep at 1000.
        reset = 1'b0;
        cycle();
        check("f0_strobe", 32'(frame_strobe), 32'd1);
        check("f0_idx",    32'(frame_idx),    32'd0);
        check("f0_out_t0", 32'(out),          32'd0);
        check("f0_err",    32'(sweep_err),    32'd0);
        prev_cyc = cyc;
        run_to(79);   check("f0_t79",   32'(out), 32'd0);
        cycle();      check("f0_t80",   32'(out), 32'd1);
        run_to(199);  check("f0_t199",  32'(out), 32'd1);
        cycle();      check("f0_t200",  32'(out), 32'd0);
        run_to(299);  check("f0_t299",  32'(out), 32'd0);
        cycle();      check("f0_t300",  32'(out), 32'd1);
        run_to(999);  check("f0_t999",  32'(out), 32'd1);
        cycle();      check("f0_t1000", 32'(out), 32'd0);
        run_to(1009); check("f0_t1009", 32'(out), 32'd0);
        cycle();      check("f0_t1010", 32'(out), 32'd1);
        run_to(1999); check("f0_t1999", 32'(out), 32'd1);

        // Frame 1: L0=90, L1=110.
        cycle();
        check("f1_strobe", 32'(frame_strobe), 32'd1);
        check("f1_idx",    32'(frame_idx),    32'd1);
        check("f1_period", 32'(cyc - prev_cyc), 32'd2000);
        prev_cyc = cyc;
        run_to(89);  check("f1_t89",  32'(out), 32'd0);
        cycle();     check("f1_t90",  32'(out), 32'd1);
        run_to(309); check("f1_t309", 32'(out), 32'd0);
        cycle();     check("f1_t310", 32'(out), 32'd1);
        data0 = 1'b0; data1 = 1'b0;

        // Frame 2: L0=100, L1=60.
        run_to(0);
        check("f2_idx",    32'(frame_idx),      32'd2);
        check("f2_period", 32'(cyc - prev_cyc), 32'd2000);
        prev_cyc = cyc;
        run_to(99);  check("f2_t99",  32'(out), 32'd0);
        cycle();     check("f2_t100", 32'(out), 32'd1);
        run_to(259); check("f2_t259", 32'(out), 32'd0);
        cycle();     check("f2_t260", 32'(out), 32'd1);

        run_to(0);
        check("f3_idx",    32'(frame_idx),      32'd3);
        check("f3_period", 32'(cyc - prev_cyc), 32'd2000);
        prev_cyc = cyc;
        run_to(0);
        check("f4_idx",    32'(frame_idx),      32'd0);
        check("f4_period", 32'(cyc - prev_cyc), 32'd2000);

        // Sweep window boundaries.
        sweep_time = WIDTH'(339);
        run_to(0);   check("s339_err", 32'(sweep_err), 32'd1);
        run_to(339); check("s339_t339", 32'(out), 32'd1);
        run_to(345); check("s339_t345", 32'(out), 32'd1);
        sweep_time = WIDTH'(340);
        run_to(0);   check("s340_err", 32'(sweep_err), 32'd0);
        run_to(339); check("s340_t339", 32'(out), 32'd1);
        cycle();     check("s340_t340", 32'(out), 32'd0);
        run_to(349); check("s340_t349", 32'(out), 32'd0);
        cycle();     check("s340_t350", 32'(out), 32'd1);
        sweep_time = WIDTH'(1991);
        run_to(0);    check("s1991_err",   32'(sweep_err), 32'd1);
        run_to(1995); check("s1991_t1995", 32'(out), 32'd1);
        sweep_time = WIDTH'(1990);
        run_to(0);    check("s1990_err",   32'(sweep_err), 32'd0);
        run_to(1989); check("s1990_t1989", 32'(out), 32'd1);
        cycle();      check("s1990_t1990", 32'(out), 32'd0);
        run_to(1999); check("s1990_t1999", 32'(out), 32'd0);
        cycle();
        check("wrap_strobe", 32'(frame_strobe), 32'd1);
        check("wrap_out",    32'(out),          32'd0);

        // sweep_time changing mid-frame only affects the next frame.
        sweep_time = WIDTH'(1000);
        run_to(0);
        run_to(300);  sweep_time = WIDTH'(500);
        run_to(500);  check("mid_t500",  32'(out), 32'd1);
        run_to(1000); check("mid_t1000", 32'(out), 32'd0);
        run_to(0);
        run_to(500);  check("next_t500",  32'(out), 32'd0);
        run_to(1000); check("next_t1000", 32'(out), 32'd1);

        // Abort mid-sweep, then restart with the same frame index.
        sweep_time = WIDTH'(1000);
        run_to(0);
        saved_idx = m_idx;
        run_to(1002);
        en = 1'b0;
        cycle();
        check("abort_out",    32'(out),          32'd1);
        check("abort_strobe", 32'(frame_strobe), 32'd0);
        check("abort_idx",    32'(frame_idx),    32'(saved_idx));
        repeat (3) cycle();
        check("idle_strobe", 32'(frame_strobe), 32'd0);
        en = 1'b1;
        cycle();
        check("reen_strobe", 32'(frame_strobe), 32'd1);
        check("reen_idx",    32'(frame_idx),    32'(saved_idx));
        check("reen_out",    32'(out),          32'd0);

        // Reset mid-sync1, with en held high.
        run_to(0);
        run_to(249);
        check("pre_rst_t249", 32'(out), 32'd0);
        reset = 1'b1;
        cycle();
        check("midrst_out", 32'(out),       32'd1);
        check("midrst_idx", 32'(frame_idx), 32'd0);
        reset = 1'b0;
        cycle();
        check("post_rst_strobe", 32'(frame_strobe), 32'd1);
        check("post_rst_idx",    32'(frame_idx),    32'd0);
        check("post_rst_out",    32'(out),          32'd0);
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
